gcd_sequencer: RTL and testbench

GCD_SEQUENCER -- requirements
Module: gcd_sequencer

---
 rtl/gcd_sequencer.sv | 137 +++++++++++++
 tb/tb_gcd_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_sequencer.sv
// Control sequencer for a subtract-based GCD datapath: loads two operands,
// repeatedly subtracts the smaller from the larger, and reports done or err.
module gcd_sequencer #(
    parameter int CNT_W    = 8,
    parameter int MAX_ITER = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mayor,
    input  logic             igual,
    input  logic             cero,
    output logic [1:0]       cnt_alu,
    output logic             slc_mux_a,
    output logic             slc_mux_b,
    output logic             slc_reg,
    output logic             w,
    output logic             ld_ext,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] iter
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_A = 3'd1;
    localparam logic [2:0] S_LOAD_B = 3'd2;
    localparam logic [2:0] S_CMP    = 3'd3;
    localparam logic [2:0] S_SUB    = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_ERR    = 3'd6;

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;

    localparam logic [CNT_W-1:0] ITER_LIMIT = CNT_W'(MAX_ITER);
    localparam logic [CNT_W-1:0] ITER_SAT   = '1;

    logic [2:0]       r_state;
    logic [2:0]       w_next_state;
    logic             r_dir;
    logic [CNT_W-1:0] r_iter;

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next_state = S_LOAD_A;
            S_LOAD_A: w_next_state = S_LOAD_B;
            S_LOAD_B: w_next_state = S_CMP;
            S_CMP: begin
                if (igual)                     w_next_state = S_DONE;
                else if (cero)                 w_next_state = S_ERR;
                else if (r_iter == ITER_LIMIT) w_next_state = S_ERR;
                else                           w_next_state = S_SUB;
            end
            S_SUB:    w_next_state = S_CMP;
            S_DONE:   w_next_state = S_IDLE;
            S_ERR:    if (!start) w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Direction is latched in CMP so SUB drives a stable mux selection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dir <= 1'b0;
        end else if (r_state == S_CMP) begin
            r_dir <= mayor;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_iter <= '0;
        end else if (r_state == S_IDLE && start) begin
            r_iter <= '0;
        end else if (r_state == S_SUB && r_iter != ITER_SAT) begin
            r_iter <= r_iter + CNT_W'(1);
        end
    end

    always_comb begin
        cnt_alu   = ALU_PASS;
        slc_mux_a = 1'b0;
        slc_mux_b = 1'b0;
        slc_reg   = 1'b0;
        w         = 1'b0;
        ld_ext    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        case (r_state)
            S_LOAD_A: begin
                ld_ext  = 1'b1;
                slc_reg = 1'b0;
                w       = 1'b1;
                busy    = 1'b1;
            end
            S_LOAD_B: begin
                ld_ext  = 1'b1;
                slc_reg = 1'b1;
                w       = 1'b1;
                busy    = 1'b1;
            end
            S_CMP: begin
                cnt_alu   = ALU_SUB;
                slc_mux_a = 1'b0;
                slc_mux_b = 1'b1;
                busy      = 1'b1;
            end
            S_SUB: begin
                cnt_alu   = ALU_SUB;
                slc_mux_a = ~r_dir;
                slc_mux_b = r_dir;
                slc_reg   = ~r_dir;
                w         = 1'b1;
                busy      = 1'b1;
            end
            S_DONE:  done = 1'b1;
            S_ERR:   err  = 1'b1;
            default: ;
        endcase
    end

    assign iter = r_iter;

endmodule

// File: tb/tb_gcd_sequencer.sv
// Bench for gcd_sequencer: a bench-side register file closes the loop, and an
// algorithmic GCD model predicts the per-cycle control trace of each run.
module tb_gcd_sequencer;

    localparam int CNT_W    = 8;
    localparam int MAX_ITER = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             mayor;
    logic             igual;
    logic             cero;
    logic [1:0]       cnt_alu;
    logic             slc_mux_a;
    logic             slc_mux_b;
    logic             slc_reg;
    logic             w;
    logic             ld_ext;
    logic             busy;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] iter;

    always #5 clk = ~clk;

    gcd_sequencer #(.CNT_W(CNT_W), .MAX_ITER(MAX_ITER)) dut (
        .clk(clk), .rst(rst), .start(start),
        .mayor(mayor), .igual(igual), .cero(cero),
        .cnt_alu(cnt_alu), .slc_mux_a(slc_mux_a), .slc_mux_b(slc_mux_b),
        .slc_reg(slc_reg), .w(w), .ld_ext(ld_ext),
        .busy(busy), .done(done), .err(err), .iter(iter)
    );

    // Register file and ALU driven by the sequencer's control outputs.
    logic [7:0] op_a = 8'd0;
    logic [7:0] op_b = 8'd0;
    logic [7:0] r0 = 8'd0;
    logic [7:0] r1 = 8'd0;
    logic [7:0] alu_a, alu_b, alu_y;

    always_comb begin
        alu_a = slc_mux_a ? r1 : r0;
        alu_b = slc_mux_b ? r1 : r0;
        alu_y = (cnt_alu == 2'b01) ? alu_a - alu_b : alu_a;
    end

    assign mayor = r0 > r1;
    assign igual = r0 == r1;
    assign cero  = (r0 == 8'd0) || (r1 == 8'd0);

    always @(posedge clk) begin
        if (w) begin
            if (slc_reg) r1 <= ld_ext ? op_b : alu_y;
            else         r0 <= ld_ext ? op_a : alu_y;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Control word: {cnt_alu, slc_mux_a, slc_mux_b, slc_reg, w, ld_ext, busy, done, err}
    wire [9:0] ctl_act = {cnt_alu, slc_mux_a, slc_mux_b, slc_reg, w, ld_ext, busy, done, err};

    function automatic logic [9:0] mk(input logic [1:0] alu, input logic ma, input logic mb,
                                      input logic rg, input logic we, input logic ld,
                                      input logic bs, input logic dn, input logic er);
        return {alu, ma, mb, rg, we, ld, bs, dn, er};
    endfunction

    localparam logic [9:0] CTL_IDLE = 10'd0;
    wire [9:0] ctl_load_a = mk(2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    wire [9:0] ctl_load_b = mk(2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    wire [9:0] ctl_cmp    = mk(2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    wire [9:0] ctl_sub_r0 = mk(2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    wire [9:0] ctl_sub_r1 = mk(2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    wire [9:0] ctl_done   = mk(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    wire [9:0] ctl_err    = mk(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    typedef struct {
        logic [9:0]       ctl;
        logic [CNT_W-1:0] it;
        int               cyc;
    } row_t;

    row_t exp_q[$];

    // Expected trace from the subtraction GCD algorithm: load, then compare/subtract
    // until equal (done), a zero operand or the iteration limit (err).
    task automatic push_run(input int a, input int b);
        int x = a;
        int y = b;
        int k = 0;
        int c = 1;
        exp_q.push_back('{ctl_load_a, CNT_W'(0), c}); c++;
        exp_q.push_back('{ctl_load_b, CNT_W'(0), c}); c++;
        for (int n = 0; n < 600; n++) begin
            exp_q.push_back('{ctl_cmp, CNT_W'(k), c}); c++;
            if (x == y) begin
                exp_q.push_back('{ctl_done, CNT_W'(k), c});
                break;
            end
            if (x == 0 || y == 0 || k == MAX_ITER) begin
                exp_q.push_back('{ctl_err, CNT_W'(k), c});
                break;
            end
            if (x > y) begin
                exp_q.push_back('{ctl_sub_r0, CNT_W'(k), c});
                x = x - y;
            end else begin
                exp_q.push_back('{ctl_sub_r1, CNT_W'(k), c});
                y = y - x;
            end
            c++;
            k = (k == (1 << CNT_W) - 1) ? k : k + 1;
        end
    endtask

    int last_done_cyc  = -1;
    int last_done_iter = -1;
    int last_err_cyc   = -1;
    int last_err_iter  = -1;
    int done_pulses    = 0;
    int w_count        = 0;
    row_t cur;

    always @(negedge clk) begin
        if (!rst && exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            check("ctl_trace", 32'(ctl_act), 32'(cur.ctl));
            check("iter_trace", 32'(iter), 32'(cur.it));
            if (cur.ctl == ctl_done) begin
                last_done_cyc  = cur.cyc;
                last_done_iter = int'(iter);
                check("done_latency", 32'(cur.cyc), 32'(4 + 2 * int'(iter)));
            end
            if (cur.ctl == ctl_err) begin
                last_err_cyc  = cur.cyc;
                last_err_iter = int'(iter);
            end
        end
    end

    always @(negedge clk) begin
        if (done) done_pulses++;
        if (w)    w_count++;
    end

    task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic hold);
        @(negedge clk);
        #2;
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        push_run(int'(a), int'(b));
        if (!hold) start = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 300; n++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
            #1;
        end
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
        #1;
    endtask

    task automatic check_idle(input string name, input int exp_iter);
        check(name, 32'(ctl_act), 32'(CTL_IDLE));
        check(name, 32'(iter), 32'(exp_iter));
    endtask

    int dp0;
    int wc0;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        check_idle("reset_state", 0);
        rst = 1'b0;
        @(negedge clk);
        #2;
        check_idle("idle_after_reset", 0);

        // Equal operands: done in cycle 4 with no subtractions.
        dp0 = done_pulses;
        launch(8'd7, 8'd7, 1'b0);
        drain();
        check("eq_done_cyc", 32'(last_done_cyc), 32'd4);
        check("eq_iter", 32'(last_done_iter), 32'd0);
        check("eq_r0", 32'(r0), 32'd7);
        check("eq_done_pulses", 32'(done_pulses - dp0), 32'd1);
        @(negedge clk);
        #2;
        check_idle("eq_back_idle", 0);

        // 12 and 8: two subtractions, R0 first then R1.
        launch(8'd12, 8'd8, 1'b0);
        drain();
        check("g12_8_done_cyc", 32'(last_done_cyc), 32'd8);
        check("g12_8_iter", 32'(last_done_iter), 32'd2);
        check("g12_8_r0", 32'(r0), 32'd4);
        check("g12_8_r1", 32'(r1), 32'd4);
        repeat (2) begin
            @(negedge clk);
            #2;
            check_idle("g12_8_iter_hold", 2);
        end

        // Zero operand with start held: err held, then idle once start drops.
        wc0 = w_count;
        launch(8'd0, 8'd5, 1'b1);
        drain();
        check("zero_err_cyc", 32'(last_err_cyc), 32'd4);
        repeat (3) begin
            @(negedge clk);
            #2;
            check("zero_err_hold", 32'(ctl_act), 32'(ctl_err));
        end
        start = 1'b0;
        @(negedge clk);
        #2;
        check_idle("zero_back_idle", 0);
        check("zero_w_pulses", 32'(w_count - wc0), 32'd2);

        // Iteration limit: 100,1 errors after exactly MAX_ITER subtractions.
        launch(8'd100, 8'd1, 1'b0);
        drain();
        check("limit_err_cyc", 32'(last_err_cyc), 32'd10);
        check("limit_iter", 32'(last_err_iter), 32'd3);
        check("limit_r0", 32'(r0), 32'd97);
        @(negedge clk);
        #2;
        check_idle("limit_back_idle", 3);

        // Reset asserted asynchronously while in the first SUB of a 12,8 run.
        launch(8'd12, 8'd8, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check_idle("async_reset", 0);
        wc0 = w_count;
        repeat (2) @(negedge clk);
        #2;
        check("reset_no_w", 32'(w_count - wc0), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        #2;
        check_idle("post_reset_idle", 0);
        launch(8'd12, 8'd8, 1'b0);
        drain();
        check("post_reset_cyc", 32'(last_done_cyc), 32'd8);
        check("post_reset_r0", 32'(r0), 32'd4);

        // Start pulsed during CMP and SUB is ignored.
        @(negedge clk);
        dp0 = done_pulses;
        launch(8'd12, 8'd8, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        start = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        start = 1'b0;
        drain();
        check("ignore_done_pulses", 32'(done_pulses - dp0), 32'd1);
        check("ignore_iter", 32'(last_done_iter), 32'd2);
        check("ignore_cyc", 32'(last_done_cyc), 32'd8);

        // Start held through DONE relaunches after one IDLE cycle.
        @(negedge clk);
        dp0 = done_pulses;
        launch(8'd9, 8'd3, 1'b1);
        exp_q.push_back('{CTL_IDLE, CNT_W'(2), 9});
        push_run(9, 3);
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            #2;
            if (done) break;
        end
        check("hold_first_done", 32'(done), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        drain();
        check("hold_done_pulses", 32'(done_pulses - dp0), 32'd2);
        check("hold_iter", 32'(last_done_iter), 32'd2);
        check("hold_r0", 32'(r0), 32'd3);
        @(negedge clk);
        #2;
        check_idle("final_idle", 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
